// File: rtl/arm1_pkg.sv
// arm1_pkg: shared opcodes, output-port state encoding and default data width
// for the ARM1 output-port stage.
`default_nettype none

package arm1_pkg;

  localparam logic [3:0] OP_OUT      = 4'b1010;
  localparam logic [3:0] OP_HLT      = 4'b1111;
  localparam int         ARM1_DATA_W = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } out_state_e;

endpackage

`default_nettype wire

// File: rtl/arm1_sync_fifo.sv
// arm1_sync_fifo: power-of-two circular buffer with full/empty flags.
// Storage is deliberately unreset; only pointers and count are cleared.
`default_nettype none

module arm1_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_CNT_W  = c_ADDR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                w_do_push;
  logic                w_do_pop;

  assign o_full    = (r_count == c_FULL);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full buffer is allowed only when the head leaves this cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/arm1_out_port.sv
// arm1_out_port: buffers core OUT writes and drains them over valid/ready,
// tracking HLT to report drained. Optional word_count via ARM1_OUT_COUNT_EN.
`default_nettype none

module arm1_out_port
  import arm1_pkg::*;
#(
  parameter int DATA_W = ARM1_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              out_we,
  input  logic [DATA_W-1:0] out_data,
  input  logic              halted,
  output logic              stall,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              overflow,
  output logic              drained
`ifdef ARM1_OUT_COUNT_EN
  ,
  output logic [15:0]       word_count
`endif
);

  out_state_e r_state;
  out_state_e w_state_next;
  logic       r_overflow;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;

  assign w_pop  = !w_empty && m_ready;
  assign w_push = out_we && (r_state == RUN) && (!w_full || w_pop);
  assign w_drop = out_we && !w_push;

  arm1_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (out_data),
    .o_rdata (m_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign stall    = w_full;
  assign m_valid  = !w_empty;
  assign overflow = r_overflow;
  assign drained  = (r_state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (halted)  w_state_next = FLUSH;
      FLUSH:   if (w_empty) w_state_next = DONE;
      DONE:    w_state_next = DONE;
      default: w_state_next = RUN;
    endcase
  end

`ifdef ARM1_OUT_COUNT_EN
  logic [15:0] r_word_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_word_count <= '0;
    else if (w_pop) r_word_count <= r_word_count + 16'd1;
  end

  assign word_count = r_word_count;
`else
  // Delivery counter not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_arm1_out_port.sv
// tb_arm1_out_port: directed self-checking bench for arm1_out_port.
`default_nettype none

module tb_arm1_out_port;

  logic       clk;
  logic       reset;
  logic       out_we;
  logic [7:0] out_data;
  logic       halted;
  logic       stall;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic       overflow;
  logic       drained;
`ifdef ARM1_OUT_COUNT_EN
  logic [15:0] word_count;
`endif

  int errors;
  int checks;

  arm1_out_port #(
    .DATA_W (8),
    .DEPTH  (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .out_we   (out_we),
    .out_data (out_data),
    .halted   (halted),
    .stall    (stall),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .overflow (overflow),
    .drained  (drained)
`ifdef ARM1_OUT_COUNT_EN
    ,
    .word_count (word_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; out_we = 1'b0; m_ready = 1'b0; halted = 1'b0; out_data = 8'h00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write_word(input logic [7:0] d);
    out_we = 1'b1; out_data = d;
    tick();
    out_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_we = 1'b0; m_ready = 1'b0; halted = 1'b0; out_data = 8'h00;
    tick();
    tick();
    checks++; if (m_valid !== 1'b0)  begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    checks++; if (stall !== 1'b0)    begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (drained !== 1'b0)  begin errors++; $display("FAIL reset_drained got=%b exp=0", drained); end
`ifdef ARM1_OUT_COUNT_EN
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_single_word();
    do_reset();
    m_ready = 1'b1;
    write_word(8'h2A);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", m_valid); end
    checks++; if (m_data !== 8'h2A) begin errors++; $display("FAIL single_data got=%h exp=2a", m_data); end
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_one_cycle got=%b exp=0", m_valid); end
`ifdef ARM1_OUT_COUNT_EN
    checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL single_word_count got=%0d exp=1", word_count); end
`endif
    m_ready = 1'b0;
  endtask

  task automatic test_fill_backpressure();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      write_word(8'(i));
      if (i == 3) begin
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fill_stall_3 got=%b exp=0", stall); end
      end
    end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fill_stall_4 got=%b exp=1", stall); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_no_overflow got=%b exp=0", overflow); end
    write_word(8'h05);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got=%b exp=1", overflow); end
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (m_data !== 8'(i)) begin errors++; $display("FAIL fill_order got=%h exp=%h", m_data, 8'(i)); end
      tick();
      if (i == 1) begin
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fill_stall_fall got=%b exp=0", stall); end
      end
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL fill_empty got=%b exp=0", m_valid); end
`ifdef ARM1_OUT_COUNT_EN
    checks++; if (word_count !== 16'd4) begin errors++; $display("FAIL fill_word_count got=%0d exp=4", word_count); end
`endif
    m_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 4; i++) write_word(8'h10 + 8'(i));
    m_ready = 1'b1; out_we = 1'b1; out_data = 8'h14;
    checks++; if (m_data !== 8'h10) begin errors++; $display("FAIL fpp_head got=%h exp=10", m_data); end
    tick();
    out_we = 1'b0;
    checks++; if (stall !== 1'b1)    begin errors++; $display("FAIL fpp_still_full got=%b exp=1", stall); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow got=%b exp=0", overflow); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (m_data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL fpp_order got=%h exp=%h", m_data, 8'h10 + 8'(i)); end
      tick();
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty got=%b exp=0", m_valid); end
    m_ready = 1'b0;
  endtask

  task automatic test_wrap_around();
    int sent;
    int rcv;
    do_reset();
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 60 && rcv < 10; cyc++) begin
      out_we   = (sent < 10) && !stall;
      out_data = 8'(sent);
      m_ready  = cyc[0];
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== 8'(rcv)) begin errors++; $display("FAIL wrap_order got=%h exp=%h", m_data, 8'(rcv)); end
        rcv++;
      end
      if (out_we) sent++;
      tick();
    end
    out_we = 1'b0; m_ready = 1'b0;
    checks++; if (rcv != 10) begin errors++; $display("FAIL wrap_timeout got=%0d words exp=10", rcv); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_halt_flush();
    do_reset();
    write_word(8'hA1);
    write_word(8'hA2);
    halted = 1'b1;
    tick();
    tick();
    checks++; if (drained !== 1'b0) begin errors++; $display("FAIL halt_not_drained got=%b exp=0", drained); end
    m_ready = 1'b1;
    checks++; if (m_data !== 8'hA1) begin errors++; $display("FAIL halt_first got=%h exp=a1", m_data); end
    tick();
    checks++; if (m_data !== 8'hA2) begin errors++; $display("FAIL halt_second got=%h exp=a2", m_data); end
    tick();
    checks++; if (drained !== 1'b0) begin errors++; $display("FAIL halt_early_drained got=%b exp=0", drained); end
    tick();
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL halt_drained got=%b exp=1", drained); end
    write_word(8'hEE);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL halt_late_write_overflow got=%b exp=1", overflow); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL halt_late_write_dropped got=%b exp=0", m_valid); end
    halted = 1'b0; m_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) write_word(8'h30 + 8'(i));
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got=%b exp=1", m_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0)  begin errors++; $display("FAIL areset_m_valid got=%b exp=0", m_valid); end
    checks++; if (stall !== 1'b0)    begin errors++; $display("FAIL areset_stall got=%b exp=0", stall); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL areset_overflow got=%b exp=0", overflow); end
    checks++; if (drained !== 1'b0)  begin errors++; $display("FAIL areset_drained got=%b exp=0", drained); end
`ifdef ARM1_OUT_COUNT_EN
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL areset_word_count got=%0d exp=0", word_count); end
`endif
    tick();
    reset = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_word();
    test_fill_backpressure();
    test_full_push_pop();
    test_wrap_around();
    test_halt_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
